// File: rtl/eth_pkg.sv
// eth_pkg: Ethernet/ARP constants, TX state encoding and field bundle shared by
// the ARP transmit path and the CRC helper.
package eth_pkg;
    localparam logic [15:0] HTYPE         = 16'h0001;
    localparam logic [15:0] PTYPE         = 16'h0800;
    localparam logic [7:0]  HLEN          = 8'h06;
    localparam logic [7:0]  PLEN          = 8'h04;
    localparam logic [15:0] OPER_RQ       = 16'h0001;
    localparam logic [15:0] OPER_RESP     = 16'h0002;
    localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
    localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MAC_Z         = 48'h0;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;

    localparam int PREAMBLE_LEN = 7;
    localparam int SFD_LEN      = 1;
    localparam int HEADER_LEN   = 14;
    localparam int PAYLOAD_LEN  = 28;
    localparam int PAD_LEN      = 18;
    localparam int FCS_LEN      = 4;

    typedef enum logic [2:0] {
        ARP_TX_IDLE,
        ARP_TX_PREAMBLE,
        ARP_TX_SFD,
        ARP_TX_HEADER,
        ARP_TX_PAYLOAD,
        ARP_TX_PAD,
        ARP_TX_FCS,
        ARP_TX_IFG
    } arp_tx_state_t;

    typedef struct packed {
        logic        oper;
        logic [47:0] local_mac;
        logic [31:0] local_ip;
        logic [47:0] target_mac;
        logic [31:0] target_ip;
    } arp_tx_fields_t;

    // IDLE and IFG report 1; the IFG length is a parameter of the user.
    function automatic int state_len(arp_tx_state_t s);
        return s == ARP_TX_PREAMBLE ? PREAMBLE_LEN :
               s == ARP_TX_SFD      ? SFD_LEN      :
               s == ARP_TX_HEADER   ? HEADER_LEN   :
               s == ARP_TX_PAYLOAD  ? PAYLOAD_LEN  :
               s == ARP_TX_PAD      ? PAD_LEN      :
               s == ARP_TX_FCS      ? FCS_LEN      : 1;
    endfunction

    function automatic arp_tx_state_t next_state(arp_tx_state_t s);
        return s == ARP_TX_PREAMBLE ? ARP_TX_SFD     :
               s == ARP_TX_SFD      ? ARP_TX_HEADER  :
               s == ARP_TX_HEADER   ? ARP_TX_PAYLOAD :
               s == ARP_TX_PAYLOAD  ? ARP_TX_PAD     :
               s == ARP_TX_PAD      ? ARP_TX_FCS     :
               s == ARP_TX_FCS      ? ARP_TX_IFG     : ARP_TX_IDLE;
    endfunction
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: next CRC32 register value after one byte, reflected polynomial,
// LSB of the byte first. Purely combinational.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);
    always_comb begin
        crc_o = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++)
            crc_o = crc_o[0] ? (crc_o >> 1) ^ CRC32_POLY : crc_o >> 1;
    end
endmodule

// File: rtl/arp_handler_tx.sv
// arp_handler_tx: serialises one Ethernet II ARP request/reply frame onto GMII TX
// per accepted request, followed by the inter-frame gap.
module arp_handler_tx
    import eth_pkg::*;
#(
    parameter int IFG_BYTES = 12
) (
    input  logic        mac_gmii_tx_clk,
    input  logic        mac_gmii_tx_rst,
    input  logic        arp_tx_req,
    input  logic        arp_tx_oper,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [47:0] target_mac,
    input  logic [31:0] target_ip,
    output logic        arp_tx_ready,
    output logic        arp_tx_done,
    output logic [7:0]  mac_gmii_txd,
    output logic        mac_gmii_tx_en,
    output logic        mac_gmii_tx_er
);
    localparam int CNT_W = IFG_BYTES > 31 ? $clog2(IFG_BYTES) : 5;

    arp_tx_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    arp_tx_fields_t   fields_q, fields_d;
    logic [31:0]      crc_q, crc_d, crc_next, fcs_sh;
    logic [7:0]       txd_q, txd_d;
    logic             tx_en_q, tx_en_d, done_q, done_d, ready_q, ready_d;
    logic             accept, cnt_last;
    logic [111:0]     hdr, hdr_sh;
    logic [223:0]     pay, pay_sh;
    int               last;

    // Everything is computed for the byte about to be registered (state_d/cnt_d),
    // so the output register holds the byte of the state it has just entered.
    always_comb begin
        last     = state_q == ARP_TX_IFG ? IFG_BYTES - 1 : state_len(state_q) - 1;
        cnt_last = int'(cnt_q) == last;
        accept   = state_q == ARP_TX_IDLE && arp_tx_req;
        fields_d = accept ? {arp_tx_oper, local_mac, local_ip, target_mac, target_ip} : fields_q;
        state_d  = accept ? ARP_TX_PREAMBLE :
                   (state_q != ARP_TX_IDLE && cnt_last) ? next_state(state_q) : state_q;
        cnt_d    = (accept || cnt_last) ? '0 : cnt_q + CNT_W'(1);
        hdr      = {fields_q.oper ? fields_q.target_mac : MAC_BCAST, fields_q.local_mac, ETHERTYPE_ARP};
        pay      = {HTYPE, PTYPE, HLEN, PLEN, fields_q.oper ? OPER_RESP : OPER_RQ,
                    fields_q.local_mac, fields_q.local_ip,
                    fields_q.oper ? fields_q.target_mac : MAC_Z, fields_q.target_ip};
        hdr_sh   = hdr << {cnt_d, 3'b000};
        pay_sh   = pay << {cnt_d, 3'b000};
        fcs_sh   = ~crc_q >> {cnt_d, 3'b000};
        txd_d    = state_d == ARP_TX_PREAMBLE ? PREAMBLE_BYTE :
                   state_d == ARP_TX_SFD      ? SFD_BYTE      :
                   state_d == ARP_TX_HEADER   ? hdr_sh[111:104] :
                   state_d == ARP_TX_PAYLOAD  ? pay_sh[223:216] :
                   state_d == ARP_TX_FCS      ? fcs_sh[7:0]   : 8'h00;
        tx_en_d  = !(state_d inside {ARP_TX_IDLE, ARP_TX_IFG});
        done_d   = state_q == ARP_TX_FCS && cnt_last;
        ready_d  = state_d == ARP_TX_IDLE;
    end

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (txd_d),
        .crc_o  (crc_next)
    );

    // The register already holds all 60 frame bytes when the first FCS byte is formed.
    always_comb begin
        crc_d = state_d == ARP_TX_SFD ? CRC32_INIT :
                (state_d inside {ARP_TX_HEADER, ARP_TX_PAYLOAD, ARP_TX_PAD}) ? crc_next : crc_q;
    end

    always_ff @(posedge mac_gmii_tx_clk or posedge mac_gmii_tx_rst) begin
        if (mac_gmii_tx_rst) begin
            state_q  <= ARP_TX_IDLE;
            cnt_q    <= '0;
            fields_q <= '0;
            crc_q    <= CRC32_INIT;
            txd_q    <= 8'h00;
            tx_en_q  <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fields_q <= fields_d;
            crc_q    <= crc_d;
            txd_q    <= txd_d;
            tx_en_q  <= tx_en_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign mac_gmii_txd   = txd_q;
    assign mac_gmii_tx_en = tx_en_q;
    assign mac_gmii_tx_er = 1'b0;
    assign arp_tx_done    = done_q;
    assign arp_tx_ready   = ready_q;
endmodule

// File: tb/tb_arp_handler_tx.sv
// tb_arp_handler_tx: directed and randomized ARP frames checked byte-by-byte
// against a frame model built from the field layout, plus timing and reset cases.
module tb_arp_handler_tx;
    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, oper = 1'b0;
    logic [47:0] lmac = '0, tmac = '0;
    logic [31:0] lip = '0, tip = '0;
    logic        ready, done, tx_en, tx_er;
    logic [7:0]  txd;

    int n_assert = 0, n_fail = 0;
    logic [7:0] c_txd [0:90];
    logic       c_en [0:90], c_done [0:90], c_rdy [0:90];
    logic [7:0] exp_b [0:71];

    arp_handler_tx #(.IFG_BYTES(12)) dut (
        .mac_gmii_tx_clk (clk),
        .mac_gmii_tx_rst (rst),
        .arp_tx_req      (req),
        .arp_tx_oper     (oper),
        .local_mac       (lmac),
        .local_ip        (lip),
        .target_mac      (tmac),
        .target_ip       (tip),
        .arp_tx_ready    (ready),
        .arp_tx_done     (done),
        .mac_gmii_txd    (txd),
        .mac_gmii_tx_en  (tx_en),
        .mac_gmii_tx_er  (tx_er)
    );

    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Bit-serial CRC32, one message bit per step, LSB of each byte first.
    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] b);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    function automatic logic [63:0] grab(input int k0, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[55:0], c_txd[k0 + i]};
        return v;
    endfunction

    task automatic build(input bit op, input logic [47:0] lm, input logic [47:0] tm,
                         input logic [31:0] li, input logic [31:0] ti);
        logic [335:0] p;
        logic [31:0] c, fc;
        logic [7:0] b;
        p = {op ? tm : 48'hFFFF_FFFF_FFFF, lm, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
             op ? 16'h0002 : 16'h0001, lm, li, op ? tm : 48'h0, ti};
        for (int i = 0; i < 7; i++) exp_b[i] = 8'h55;
        exp_b[7] = 8'hD5;
        c = 32'hFFFF_FFFF;
        for (int o = 0; o < 60; o++) begin
            b = o < 42 ? p[335 - 8*o -: 8] : 8'h00;
            exp_b[8 + o] = b;
            c = crc_model(c, b);
        end
        fc = ~c;
        for (int j = 0; j < 4; j++) exp_b[68 + j] = fc[8*j +: 8];
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {63'h0, ready}, 64'h1);
    endtask

    task automatic run_frame(input bit op, input logic [47:0] lm, input logic [47:0] tm,
                             input logic [31:0] li, input logic [31:0] ti,
                             input bit hold, input bit poke, input string tag);
        int dcnt, rcnt;
        logic [31:0] c;
        wait_ready();
        oper = op; lmac = lm; tmac = tm; lip = li; tip = ti;
        build(op, lm, tm, li, ti);
        req = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 86; k++) begin
            @(negedge clk);
            c_txd[k] = txd; c_en[k] = tx_en; c_done[k] = done; c_rdy[k] = ready;
            if (k == 1) req = hold;
            if (poke && k == 5) tip = ~tip;
            if (poke && k == 20) req = 1'b1;
            if (poke && k == 21) req = 1'b0;
        end
        for (int k = 1; k <= 72; k++)
            chk($sformatf("%s byte%0d", tag, k - 1), {55'h0, c_en[k], c_txd[k]}, {55'h0, 1'b1, exp_b[k-1]});
        chk({tag, " end73"}, {54'h0, c_en[73], c_txd[73], c_done[73]}, {54'h0, 1'b0, 8'h00, 1'b1});
        dcnt = 0; rcnt = 0;
        for (int k = 1; k <= 85; k++) dcnt += int'(c_done[k]);
        for (int k = 1; k <= 84; k++) rcnt += int'(c_rdy[k]);
        chk({tag, " done_count"}, 64'(dcnt), 64'd1);
        chk({tag, " ready_low_count"}, 64'(rcnt), 64'd0);
        chk({tag, " ready85"}, {63'h0, c_rdy[85]}, 64'h1);
        chk({tag, " cycle86"}, {55'h0, c_en[86], c_txd[86]}, hold ? {55'h0, 1'b1, 8'h55} : 64'h0);
        c = 32'hFFFF_FFFF;
        for (int k = 9; k <= 72; k++) c = crc_model(c, c_txd[k]);
        chk({tag, " residue"}, {32'h0, c}, {32'h0, 32'hDEBB20E3});
        req = 1'b0;
    endtask

    initial begin
        logic [47:0] lm0, tm0;
        logic [31:0] li0, ti0;
        int cnt;
        lm0 = 48'h02_00_00_00_00_01; tm0 = 48'h02_00_00_00_00_02;
        li0 = 32'hC0A8010A; ti0 = 32'hC0A80114;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {53'h0, txd, tx_en, tx_er, ready, done}, {53'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
        rst = 1'b0;

        run_frame(1'b1, lm0, tm0, li0, ti0, 1'b0, 1'b0, "reply");
        chk("reply dest", grab(9, 6), 64'h0000_0200_0000_0002);
        chk("reply oper", grab(29, 2), 64'h0002);

        run_frame(1'b0, lm0, tm0, li0, ti0, 1'b0, 1'b0, "request");
        chk("request dest", grab(9, 6), 64'h0000_FFFF_FFFF_FFFF);
        chk("request oper", grab(29, 2), 64'h0001);
        chk("request tha", grab(41, 6), 64'h0);
        chk("request tpa", grab(47, 4), 64'hC0A80114);

        run_frame(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, 1'b1, 1'b0, "held");

        run_frame(1'b1, lm0, tm0, li0, ti0, 1'b0, 1'b1, "busy");
        chk("busy tpa latched", grab(47, 4), 64'hC0A80114);

        wait_ready();
        oper = 1'b1; req = 1'b1;
        @(posedge clk);
        for (int k = 1; k < 30; k++) begin
            @(negedge clk);
            if (k == 1) req = 1'b0;
        end
        chk("pre_reset tx_en", {63'h0, tx_en}, 64'h1);
        rst = 1'b1;
        #1;
        chk("reset_async", {54'h0, txd, tx_en, ready}, {54'h0, 8'h00, 1'b0, 1'b1});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            cnt += int'(done) + int'(tx_en) + int'(!ready);
        end
        chk("post_reset quiet", 64'(cnt), 64'd0);
        run_frame(1'b0, lm0, tm0, li0, ti0, 1'b0, 1'b0, "after_reset");

        for (int r = 0; r < 4; r++)
            run_frame(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom,
                      1'b0, 1'b0, $sformatf("rand%0d", r));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
